// File: rtl/binary_counter_4_bit.sv
`default_nettype none
// ============================================================================
// Module      : binary_counter_4_bit
// Description : Free-running 4-bit binary counter for a board demo, shown on
//               a 4-digit common-anode 7-segment display.
//               - A tick prescaler divides clk into the count increment.
//               - A scan prescaler time-multiplexes the four digits.
//               - Default (bit mode): digit i shows count[i] as '0' or '1';
//                 digit 0 (rightmost) is the LSB.
//               - HEX_DISPLAY_EN defined (hex mode): digit 0 shows the count
//                 as a hex glyph and digits 1-3 are blank. Anode scanning is
//                 the same in both modes.
// Parameters  : TICK_DIV - clk cycles per count increment (>= 1)
//               SCAN_DIV - clk cycles per digit-scan step  (>= 1)
// Ports       : clk     in   1  system clock, rising edge
//               switch  in   1  asynchronous active-high reset
//               anode   out  4  digit enables, active-low, one-hot-low
//               cathode out  8  segments, active-low, {dp,g,f,e,d,c,b,a}
// Revision    : 1.0 - initial release
// ============================================================================
module binary_counter_4_bit #(
    parameter int TICK_DIV = 100_000_000,
    parameter int SCAN_DIV = 100_000
) (
    input  logic       clk,
    input  logic       switch,
    output logic [3:0] anode,
    output logic [7:0] cathode
);

    // A divider of 1 still needs a 1-bit register; it simply wraps every edge.
    localparam int c_TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(SCAN_DIV - 1);

    // Active-low segment patterns, dp off.
    localparam logic [7:0] c_SEG_ZERO  = 8'hC0;
    localparam logic [7:0] c_SEG_ONE   = 8'hF9;
    localparam logic [7:0] c_SEG_BLANK = 8'hFF;

    logic [c_TICK_W-1:0] r_tick_cnt;
    logic [c_SCAN_W-1:0] r_scan_cnt;
    logic [3:0]          r_count;
    logic [1:0]          r_scan_idx;

    logic w_tick_wrap;
    logic w_scan_wrap;

    assign w_tick_wrap = (r_tick_cnt == c_TICK_LAST);
    assign w_scan_wrap = (r_scan_cnt == c_SCAN_LAST);

    // Count path: the count steps on the same edge the prescaler wraps, so the
    // first increment lands on the TICK_DIV-th edge after reset release.
    always_ff @(posedge clk or posedge switch) begin
        if (switch) begin
            r_tick_cnt <= '0;
            r_count    <= 4'd0;
        end else if (w_tick_wrap) begin
            r_tick_cnt <= '0;
            r_count    <= r_count + 4'd1;   // 4'hF rolls to 4'h0 silently
        end else begin
            r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
        end
    end

    // Scan path runs independently of the count path.
    always_ff @(posedge clk or posedge switch) begin
        if (switch) begin
            r_scan_cnt <= '0;
            r_scan_idx <= 2'd0;
        end else if (w_scan_wrap) begin
            r_scan_cnt <= '0;
            r_scan_idx <= r_scan_idx + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + c_SCAN_W'(1);
        end
    end

    // Digit select: exactly one anode low for every scan index.
    always_comb begin
        anode = 4'b1110;
        case (r_scan_idx)
            2'd0:    anode = 4'b1110;
            2'd1:    anode = 4'b1101;
            2'd2:    anode = 4'b1011;
            default: anode = 4'b0111;
        endcase
    end

`ifdef HEX_DISPLAY_EN
    logic [7:0] w_glyph;

    always_comb begin
        w_glyph = c_SEG_ZERO;
        case (r_count)
            4'h0:    w_glyph = 8'hC0;
            4'h1:    w_glyph = 8'hF9;
            4'h2:    w_glyph = 8'hA4;
            4'h3:    w_glyph = 8'hB0;
            4'h4:    w_glyph = 8'h99;
            4'h5:    w_glyph = 8'h92;
            4'h6:    w_glyph = 8'h82;
            4'h7:    w_glyph = 8'hF8;
            4'h8:    w_glyph = 8'h80;
            4'h9:    w_glyph = 8'h90;
            4'hA:    w_glyph = 8'h88;
            4'hB:    w_glyph = 8'h83;
            4'hC:    w_glyph = 8'hC6;
            4'hD:    w_glyph = 8'hA1;
            4'hE:    w_glyph = 8'h86;
            default: w_glyph = 8'h8E;
        endcase
    end

    // Only the rightmost digit carries the value; the rest stay dark.
    always_comb begin
        cathode = c_SEG_BLANK;
        if (r_scan_idx == 2'd0) begin
            cathode = w_glyph;
        end
    end
`else
    // Each digit shows the count bit matching its position.
    always_comb begin
        cathode = c_SEG_ZERO;
        if (r_count[r_scan_idx]) begin
            cathode = c_SEG_ONE;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_binary_counter_4_bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_binary_counter_4_bit
// Description : Self-checking bench for binary_counter_4_bit with TICK_DIV=4,
//               SCAN_DIV=2 and a 10 ns clock. Expected display values come
//               from an edge-count model: after n edges since reset release,
//               count = (n/TICK_DIV) mod 16 and scan index = (n/SCAN_DIV)
//               mod 4. Expectations are queued as stimulus is applied and
//               popped when the DUT outputs are sampled 1 ns after the edge.
//               Honours HEX_DISPLAY_EN the same way the design does.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_binary_counter_4_bit;

    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;

    typedef struct packed {
        logic [3:0] anode;
        logic [7:0] cathode;
    } exp_t;

    logic       clk = 1'b0;
    logic       switch;
    logic [3:0] anode;
    logic [7:0] cathode;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_edge   = 0;
    exp_t q_exp[$];

    always #5 clk = ~clk;

    binary_counter_4_bit #(
        .TICK_DIV(TICK_DIV),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk    (clk),
        .switch (switch),
        .anode  (anode),
        .cathode(cathode)
    );

    function automatic logic [7:0] hex_glyph(input logic [3:0] v);
        logic [7:0] tbl [16];
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return tbl[v];
    endfunction

    // Expected outputs after n rising edges since reset release.
    function automatic exp_t model(input int n);
        exp_t       e;
        logic [3:0] cnt;
        int         idx;
        logic [3:0] one;
        cnt       = 4'((n / TICK_DIV) % 16);
        idx       = (n / SCAN_DIV) % 4;
        one       = 4'b0001;
        e.anode   = ~(one << idx);
`ifdef HEX_DISPLAY_EN
        e.cathode = (idx == 0) ? hex_glyph(cnt) : 8'hFF;
`else
        e.cathode = cnt[idx] ? 8'hF9 : 8'hC0;
`endif
        return e;
    endfunction

    task automatic check_out(input string tag);
        exp_t e;
        if (q_exp.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: scoreboard empty, got anode=%b cathode=%h", tag, anode, cathode);
        end else begin
            e = q_exp.pop_front();
            n_assert++;
            assert (anode === e.anode)
            else begin
                n_fail++;
                $error("FAIL %s anode: got %b expected %b", tag, anode, e.anode);
            end
            n_assert++;
            assert (cathode === e.cathode)
            else begin
                n_fail++;
                $error("FAIL %s cathode: got %h expected %h", tag, cathode, e.cathode);
            end
        end
    endtask

    // Advance k edges, checking the display after every one.
    task automatic run_edges(input int k);
        for (int i = 0; i < k; i++) begin
            q_exp.push_back(model(n_edge + 1));
            @(posedge clk);
            #1;
            n_edge++;
            check_out($sformatf("edge%0d", n_edge));
        end
    endtask

    initial begin
        // Reset asserted from time zero; first rising edge is at 5 ns.
        switch = 1'b1;
        #1;
        q_exp.push_back(model(0));
        check_out("reset_no_edge");

        // Reset holds state across clock edges.
        repeat (2) @(posedge clk);
        #1;
        q_exp.push_back(model(0));
        check_out("reset_hold");

        // Release between edges; covers first increment at edge 4, the
        // 8-edge scan cycle, count 4'b1010 and the 15->0 wrap at edge 64.
        @(negedge clk);
        switch = 1'b0;
        n_edge = 0;
        run_edges(93);          // count = 7, scan index 2

        // Asynchronous reset mid-count, between clock edges.
        #1;
        switch = 1'b1;
        #1;
        q_exp.push_back(model(0));
        check_out("async_reset_count7");

        @(negedge clk);
        switch = 1'b0;
        n_edge = 0;
        run_edges(12);          // increment must reappear at the 4th edge

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
